// File: rtl/mode_router.sv
// rtl/mode_router.sv - switch debounce, filtered mode select, press routing, LCD char mux; MODE_ROUTER_REPEAT_EN adds auto-repeat
module mode_router #(
  parameter int N_MODE     = 4,
  parameter int N_SW       = 4,
  parameter int DB_CYCLES  = 50000,
  parameter int SEL_STABLE = 1000,
  parameter int MODE_W     = $clog2(N_MODE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_MODE-1:0]        mode_sel,
  input  logic [N_SW-1:0]          sw_raw,
  input  logic [8*N_MODE-1:0]      data_mode,
  output logic [N_SW*N_MODE-1:0]   sw_pulse,
  output logic [N_SW-1:0]          sw_level,
  output logic [MODE_W-1:0]        mode_idx,
  output logic [7:0]               data_char,
  output logic                     guard
);

  localparam int DB_W  = $clog2(DB_CYCLES + 1);
  localparam int SEL_W = $clog2(SEL_STABLE + 1);

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_GUARD  = 1'b1
  } guard_state_e;

  logic [N_SW-1:0]   sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [N_MODE-1:0] sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
  logic [DB_W-1:0]   db_cnt_q [N_SW];
  logic [DB_W-1:0]   db_cnt_d [N_SW];
  logic [N_SW-1:0]   sw_level_q, sw_level_d;
  logic [N_SW-1:0]   sw_press_q, sw_press_d;
  logic              sel_onehot;
  logic [MODE_W-1:0] dec_idx;
  logic [MODE_W-1:0] cand_q, cand_d;
  logic [MODE_W-1:0] mode_idx_q, mode_idx_d;
  logic [SEL_W-1:0]  sel_cnt_q, sel_cnt_d, sel_cnt_base, sel_cnt_inc;
  logic              mode_change;
  guard_state_e      state_q, state_d;
  logic [7:0]        data_char_q, data_char_d;

  // Two-flop synchronizers for the asynchronous board inputs
  always_comb begin
    sw_s1_d  = sw_raw;
    sw_s2_d  = sw_s1_q;
    sel_s1_d = mode_sel;
    sel_s2_d = sel_s1_q;
  end

  // Debounce: a level flips only after DB_CYCLES consecutive disagreeing samples
  always_comb begin
    sw_level_d = sw_level_q;
    for (int s = 0; s < N_SW; s++) begin
      db_cnt_d[s] = '0;
      if (sw_s2_q[s] != sw_level_q[s]) begin
        if (db_cnt_q[s] == DB_W'(DB_CYCLES - 1)) begin
          sw_level_d[s] = ~sw_level_q[s];
        end else begin
          db_cnt_d[s] = db_cnt_q[s] + DB_W'(1);
        end
      end
    end
  end

  // Decode one-hot selector (anything else means mode 0) and filter it into mode_idx
  always_comb begin
    sel_onehot = (sel_s2_q != '0) && ((sel_s2_q & (sel_s2_q - N_MODE'(1))) == '0);
    dec_idx    = '0;
    if (sel_onehot) begin
      for (int i = 0; i < N_MODE; i++) begin
        if (sel_s2_q[i]) dec_idx = MODE_W'(i);
      end
    end
    cand_d       = dec_idx;
    mode_idx_d   = mode_idx_q;
    sel_cnt_d    = '0;
    // A new decoded value counts as the first stable cycle of a fresh run
    sel_cnt_base = (dec_idx == cand_q) ? sel_cnt_q : '0;
    sel_cnt_inc  = sel_cnt_base + SEL_W'(1);
    if (dec_idx != mode_idx_q) begin
      if (sel_cnt_inc == SEL_W'(SEL_STABLE)) begin
        mode_idx_d = dec_idx;
      end else begin
        sel_cnt_d = sel_cnt_inc;
      end
    end
    mode_change = (mode_idx_d != mode_idx_q);
  end

  // Guard FSM: suppress presses from switches still held across a mode change
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACTIVE: if (mode_change && (|sw_level_d)) state_d = ST_GUARD;
      ST_GUARD:  if (!(|sw_level_d))               state_d = ST_ACTIVE;
      default:   state_d = ST_ACTIVE;
    endcase
  end

`ifdef MODE_ROUTER_REPEAT_EN
  localparam int REPEAT_DLY = DB_CYCLES * 16;
  localparam int REPEAT_PER = DB_CYCLES * 4;
  localparam int RPT_W      = $clog2(REPEAT_DLY);

  logic [RPT_W-1:0] rpt_cnt_q [N_SW];
  logic [RPT_W-1:0] rpt_cnt_d [N_SW];
  logic [N_SW-1:0]  rpt_arm_q, rpt_arm_d, rpt_fire;

  // Auto-repeat timer per held switch: long first delay, then short period
  always_comb begin
    for (int s = 0; s < N_SW; s++) begin
      rpt_cnt_d[s] = '0;
      rpt_arm_d[s] = 1'b0;
      rpt_fire[s]  = 1'b0;
      if (sw_level_q[s] && sw_level_d[s] && !mode_change) begin
        rpt_arm_d[s] = rpt_arm_q[s];
        if (rpt_cnt_q[s] == (rpt_arm_q[s] ? RPT_W'(REPEAT_PER - 1) : RPT_W'(REPEAT_DLY - 1))) begin
          rpt_fire[s]  = 1'b1;
          rpt_arm_d[s] = 1'b1;
        end else begin
          rpt_cnt_d[s] = rpt_cnt_q[s] + RPT_W'(1);
        end
      end
    end
  end

  // Repeat timer state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rpt_arm_q <= '0;
      for (int s = 0; s < N_SW; s++) rpt_cnt_q[s] <= '0;
    end else begin
      rpt_arm_q <= rpt_arm_d;
      for (int s = 0; s < N_SW; s++) rpt_cnt_q[s] <= rpt_cnt_d[s];
    end
  end
`endif

  // Press events: debounced rising edges, plus repeats when built in
  always_comb begin
    sw_press_d = sw_level_d & ~sw_level_q;
`ifdef MODE_ROUTER_REPEAT_EN
    sw_press_d = sw_press_d | rpt_fire;
`endif
  end

  // Character mux for the current mode; out-of-range modes show blank
  always_comb begin
    data_char_d = '0;
    for (int m = 0; m < N_MODE; m++) begin
      if (mode_idx_q == MODE_W'(m)) data_char_d = data_mode[8*m +: 8];
    end
  end

  // All front-panel state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_s1_q     <= '0;
      sw_s2_q     <= '0;
      sel_s1_q    <= '0;
      sel_s2_q    <= '0;
      sw_level_q  <= '0;
      sw_press_q  <= '0;
      cand_q      <= '0;
      mode_idx_q  <= '0;
      sel_cnt_q   <= '0;
      state_q     <= ST_ACTIVE;
      data_char_q <= '0;
      for (int s = 0; s < N_SW; s++) db_cnt_q[s] <= '0;
    end else begin
      sw_s1_q     <= sw_s1_d;
      sw_s2_q     <= sw_s2_d;
      sel_s1_q    <= sel_s1_d;
      sel_s2_q    <= sel_s2_d;
      sw_level_q  <= sw_level_d;
      sw_press_q  <= sw_press_d;
      cand_q      <= cand_d;
      mode_idx_q  <= mode_idx_d;
      sel_cnt_q   <= sel_cnt_d;
      state_q     <= state_d;
      data_char_q <= data_char_d;
      for (int s = 0; s < N_SW; s++) db_cnt_q[s] <= db_cnt_d[s];
    end
  end

  // Route each press event to the active mode only, silenced while guarded
  always_comb begin
    sw_pulse = '0;
    for (int m = 0; m < N_MODE; m++) begin
      for (int s = 0; s < N_SW; s++) begin
        sw_pulse[m*N_SW + s] = sw_press_q[s] && (mode_idx_q == MODE_W'(m)) && (state_q == ST_ACTIVE);
      end
    end
  end

  assign sw_level  = sw_level_q;
  assign mode_idx  = mode_idx_q;
  assign data_char = data_char_q;
  assign guard     = (state_q == ST_GUARD);

endmodule

// File: tb/tb_mode_router.sv
// tb/tb_mode_router.sv - directed self-checking bench for mode_router
module tb_mode_router;

  localparam int N_MODE = 4;
  localparam int N_SW   = 4;
  localparam int DB     = 8;
  localparam int SEL    = 4;
  localparam int MODE_W = 2;
  localparam logic [31:0] DATA0 = 32'h44434241;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_MODE-1:0]      mode_sel;
  logic [N_SW-1:0]        sw_raw;
  logic [8*N_MODE-1:0]    data_mode;
  logic [N_SW*N_MODE-1:0] sw_pulse;
  logic [N_SW-1:0]        sw_level;
  logic [MODE_W-1:0]      mode_idx;
  logic [7:0]             data_char;
  logic                   guard;

  int checks   = 0;
  int failures = 0;

  mode_router #(
    .N_MODE(N_MODE), .N_SW(N_SW), .DB_CYCLES(DB), .SEL_STABLE(SEL), .MODE_W(MODE_W)
  ) dut (
    .clk(clk), .rst(rst), .mode_sel(mode_sel), .sw_raw(sw_raw), .data_mode(data_mode),
    .sw_pulse(sw_pulse), .sw_level(sw_level), .mode_idx(mode_idx), .data_char(data_char),
    .guard(guard)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst       = 1'b0;
    sw_raw    = 4'($urandom);
    mode_sel  = 4'($urandom);
    data_mode = $urandom;
    tick(3);
    checks++; if (sw_pulse !== 16'h0) begin failures++; $display("FAIL reset_pulse: got %h expected %h", sw_pulse, 16'h0); end
    checks++; if (sw_level !== 4'h0) begin failures++; $display("FAIL reset_level: got %h expected %h", sw_level, 4'h0); end
    checks++; if (mode_idx !== 2'd0) begin failures++; $display("FAIL reset_mode: got %0d expected %0d", mode_idx, 0); end
    checks++; if (data_char !== 8'h0) begin failures++; $display("FAIL reset_char: got %h expected %h", data_char, 8'h0); end
    checks++; if (guard !== 1'b0) begin failures++; $display("FAIL reset_guard: got %b expected %b", guard, 1'b0); end
    sw_raw    = 4'h0;
    mode_sel  = 4'b0001;
    data_mode = DATA0;
    rst       = 1'b1;
    tick(10);
    checks++; if (mode_idx !== 2'd0) begin failures++; $display("FAIL post_reset_mode: got %0d expected %0d", mode_idx, 0); end
    checks++; if (data_char !== 8'h41) begin failures++; $display("FAIL post_reset_char: got %h expected %h", data_char, 8'h41); end
  endtask

  task automatic test_bounce;
    int bad = 0;
    for (int i = 0; i < 30; i++) begin
      sw_raw[2] = ((i / 3) % 2 == 0);
      tick(1);
      if (sw_pulse !== 16'h0 || sw_level !== 4'h0) bad++;
    end
    sw_raw[2] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      if (sw_pulse !== 16'h0 || sw_level !== 4'h0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bounce_quiet: got %0d bad cycles expected %0d", bad, 0); end
    tick(1);
    checks++; if (sw_pulse !== 16'h0004) begin failures++; $display("FAIL bounce_pulse: got %h expected %h", sw_pulse, 16'h0004); end
    checks++; if (sw_level !== 4'b0100) begin failures++; $display("FAIL bounce_level: got %b expected %b", sw_level, 4'b0100); end
    tick(1);
    checks++; if (sw_pulse !== 16'h0) begin failures++; $display("FAIL bounce_one_cycle: got %h expected %h", sw_pulse, 16'h0); end
    sw_raw = 4'h0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (sw_pulse !== 16'h0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL release_no_pulse: got %0d bad cycles expected %0d", bad, 0); end
    checks++; if (sw_level !== 4'h0) begin failures++; $display("FAIL release_level: got %b expected %b", sw_level, 4'h0); end
  endtask

  task automatic test_routing;
    mode_sel = 4'b0100;
    tick(5);
    checks++; if (mode_idx !== 2'd0) begin failures++; $display("FAIL route_mode_early: got %0d expected %0d", mode_idx, 0); end
    tick(1);
    checks++; if (mode_idx !== 2'd2) begin failures++; $display("FAIL route_mode: got %0d expected %0d", mode_idx, 2); end
    checks++; if (guard !== 1'b0) begin failures++; $display("FAIL route_no_guard: got %b expected %b", guard, 1'b0); end
    checks++; if (data_char !== 8'h41) begin failures++; $display("FAIL route_char_lag: got %h expected %h", data_char, 8'h41); end
    tick(1);
    checks++; if (data_char !== 8'h43) begin failures++; $display("FAIL route_char: got %h expected %h", data_char, 8'h43); end
    data_mode[23:16] = 8'h5A;
    checks++; if (data_char !== 8'h43) begin failures++; $display("FAIL char_registered: got %h expected %h", data_char, 8'h43); end
    tick(1);
    checks++; if (data_char !== 8'h5A) begin failures++; $display("FAIL char_latency: got %h expected %h", data_char, 8'h5A); end
    data_mode = DATA0;
    tick(1);
    sw_raw = 4'b0010;
    tick(10);
    checks++; if (sw_pulse !== 16'h0200) begin failures++; $display("FAIL route_pulse: got %h expected %h", sw_pulse, 16'h0200); end
    tick(1);
    checks++; if (sw_pulse !== 16'h0) begin failures++; $display("FAIL route_pulse_end: got %h expected %h", sw_pulse, 16'h0); end
    sw_raw = 4'h0;
    tick(12);
  endtask

  task automatic test_illegal;
    int bad = 0;
    mode_sel = 4'b0110;
    tick(5);
    checks++; if (mode_idx !== 2'd2) begin failures++; $display("FAIL illegal_early: got %0d expected %0d", mode_idx, 2); end
    tick(1);
    checks++; if (mode_idx !== 2'd0) begin failures++; $display("FAIL illegal_mode: got %0d expected %0d", mode_idx, 0); end
    mode_sel = 4'b0000;
    tick(10);
    checks++; if (mode_idx !== 2'd0) begin failures++; $display("FAIL zero_sel_mode: got %0d expected %0d", mode_idx, 0); end
    mode_sel = 4'b1000;
    tick(3);
    mode_sel = 4'b0000;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (mode_idx !== 2'd0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL glitch_mode: got %0d bad cycles expected %0d", bad, 0); end
  endtask

  task automatic test_guard;
    int bad = 0;
    sw_raw = 4'b0001;
    tick(10);
    checks++; if (sw_pulse !== 16'h0001) begin failures++; $display("FAIL guard_pre_pulse: got %h expected %h", sw_pulse, 16'h0001); end
    tick(1);
    mode_sel = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      if (guard !== 1'b0 || sw_pulse !== 16'h0) bad++;
    end
    tick(1);
    checks++; if (mode_idx !== 2'd3) begin failures++; $display("FAIL guard_mode: got %0d expected %0d", mode_idx, 3); end
    checks++; if (guard !== 1'b1) begin failures++; $display("FAIL guard_rise: got %b expected %b", guard, 1'b1); end
    sw_raw = 4'b0011;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (sw_pulse !== 16'h0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL guard_suppress: got %0d bad cycles expected %0d", bad, 0); end
    checks++; if (sw_level !== 4'b0011) begin failures++; $display("FAIL guard_level: got %b expected %b", sw_level, 4'b0011); end
    sw_raw = 4'h0;
    tick(9);
    checks++; if (guard !== 1'b1) begin failures++; $display("FAIL guard_hold: got %b expected %b", guard, 1'b1); end
    tick(1);
    checks++; if (guard !== 1'b0) begin failures++; $display("FAIL guard_fall: got %b expected %b", guard, 1'b0); end
    sw_raw = 4'b0001;
    tick(10);
    checks++; if (sw_pulse !== 16'h1000) begin failures++; $display("FAIL guard_post_pulse: got %h expected %h", sw_pulse, 16'h1000); end
    sw_raw = 4'h0;
    tick(12);
  endtask

  task automatic test_repeat;
    int bad = 0;
    int cnt = 0;
    int first = -1;
    int second = -1;
    int third = -1;
    sw_raw = 4'b1000;
    for (int k = 1; k <= 400; k++) begin
      tick(1);
      if ((sw_pulse & 16'h7FFF) != 16'h0) bad++;
      if (sw_pulse[15] === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
        else if (second < 0) second = k;
        else if (third < 0) third = k;
      end
    end
    sw_raw = 4'h0;
    tick(12);
    checks++; if (bad != 0) begin failures++; $display("FAIL hold_other_bits: got %0d bad cycles expected %0d", bad, 0); end
    checks++; if (first != 10) begin failures++; $display("FAIL hold_first: got %0d expected %0d", first, 10); end
`ifdef MODE_ROUTER_REPEAT_EN
    checks++; if (cnt != 10) begin failures++; $display("FAIL hold_count: got %0d expected %0d", cnt, 10); end
    checks++; if (second != 138) begin failures++; $display("FAIL hold_second: got %0d expected %0d", second, 138); end
    checks++; if (third != 170) begin failures++; $display("FAIL hold_third: got %0d expected %0d", third, 170); end
`else
    checks++; if (cnt != 1) begin failures++; $display("FAIL hold_count: got %0d expected %0d", cnt, 1); end
    checks++; if (second != -1) begin failures++; $display("FAIL hold_second: got %0d expected %0d", second, -1); end
    checks++; if (third != -1) begin failures++; $display("FAIL hold_third: got %0d expected %0d", third, -1); end
`endif
  endtask

  task automatic test_midreset;
    int bad = 0;
    mode_sel = 4'b0001;
    sw_raw   = 4'b0100;
    tick(5);
    rst = 1'b0;
    #1;
    checks++; if (mode_idx !== 2'd0) begin failures++; $display("FAIL midrst_mode: got %0d expected %0d", mode_idx, 0); end
    checks++; if (sw_level !== 4'h0) begin failures++; $display("FAIL midrst_level: got %b expected %b", sw_level, 4'h0); end
    tick(2);
    rst = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      if (sw_level !== 4'h0 || sw_pulse !== 16'h0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL midrst_partial: got %0d bad cycles expected %0d", bad, 0); end
    tick(1);
    checks++; if (sw_level !== 4'b0100) begin failures++; $display("FAIL midrst_rise: got %b expected %b", sw_level, 4'b0100); end
    checks++; if (sw_pulse !== 16'h0004) begin failures++; $display("FAIL midrst_pulse: got %h expected %h", sw_pulse, 16'h0004); end
    sw_raw = 4'h0;
    tick(12);
  endtask

  initial begin
    rst       = 1'b0;
    sw_raw    = 4'h0;
    mode_sel  = 4'b0001;
    data_mode = DATA0;
    tick(1);
    test_reset();
    test_bounce();
    test_routing();
    test_illegal();
    test_guard();
    test_repeat();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
